bridge_1xn: RTL and testbench
=============================

Name: bridge_1xn

Overview:
Parametrised 1-to-N data-side bridge between the CPU data SRAM-like port and NSLV slaves (data sram, confreg, boot rom, peripherals). Each slave has a compile-time base/mask window with fixed priority. A select pipeline delays the read-data mux by RD_LAT cycles to match slave read latency. Accesses that hit no window are decode misses; the bridge absorbs them and reports them.

Parameters:
XLEN, 32, data/address width
NSLV, 4, number of slave ports (2..8)
RD_LAT, 1, slave read latency in cycles (1..4); depth of select pipeline
SLV_BASE, {32'h0000_0000, 32'h1f00_0000, 32'h1fc0_0000, 32'h1faf_0000}, flattened NSLV*XLEN bases; slot i is bits [i*XLEN +: XLEN], so slot 0 = 32'h1faf_0000 (confreg)
SLV_MASK, {32'h1000_0000, 32'h1f00_0000, 32'h1ff0_0000, 32'h1fff_0000}, flattened NSLV*XLEN masks, same slot order (slot 0 = 32'h1fff_0000)
MISS_DATA, 32'hdead_beef, read data returned for a decode miss

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
cpu_data_en  input  1  access request
cpu_data_wen  input  4  byte write enables; 0 = read
cpu_data_addr  input  XLEN  address
cpu_data_wdata  input  XLEN  write data
cpu_data_rdata  output  XLEN  read data, valid RD_LAT cycles after the request
slv_en  output  NSLV  per-slave enable
slv_wen  output  4*NSLV  per-slave byte enables
slv_addr  output  XLEN  broadcast address
slv_wdata  output  XLEN  broadcast write data
slv_rdata  input  XLEN*NSLV  per-slave read data
miss_pulse  output  1  one-cycle pulse for each decode miss
miss_addr  output  XLEN  address of the most recent miss

Behaviour:
- Decode (combinational): hit[i] = ((cpu_data_addr & MASK[i]) == BASE[i]). Lowest index wins, giving a one-hot sel. miss = ~|hit.
- Request path (zero latency): slv_en[i] = cpu_data_en & sel[i]; slv_wen[i] = cpu_data_wen & {4{sel[i]}}. slv_addr and slv_wdata pass through unmodified.
- On a miss no slave is enabled and writes are dropped.
- Select pipeline: RD_LAT stages, each holding {sel one-hot, miss_flag, rd_flag}.
  - Stage 0 loads every cycle with {sel & {NSLV{cpu_data_en}}, cpu_data_en & miss, cpu_data_en & ~|cpu_data_wen}.
  - Stage k loads from stage k-1 every cycle. There are no stalls; the CPU never holds a request.
- rdata mux uses last stage L:
  - cpu_data_rdata = OR over i of ({XLEN{L.sel[i]}} & slv_rdata[i]), ORed with ({XLEN{L.miss}} & MISS_DATA).
  - When L is empty (no access), rdata = 0.
  - Write-only stages still select, so a slave that returns data on writes is passed through harmlessly.
- Back-to-back accesses to different slaves every cycle each return their own slave's data. No bubble.
- Miss reporting:
  - miss_pulse is asserted in the cycle after any cpu_data_en & miss (registered), reads and writes alike.
  - miss_addr is loaded with cpu_data_addr in that same capture. It holds until the next miss.
- Reset (async, active-low):
  - All pipeline stages clear to 0.
  - miss_pulse = 0, miss_addr = 0, cpu_data_rdata = 0.
  - Slave outputs are combinational, so they follow inputs even in reset.
  - A request during reset produces no response after release.
- Overlapping windows are legal; priority resolves them. An all-zero mask makes slot i match everything, and it is used as a catch-all default.

Optional Feature:
BRIDGE_MISS_CNT_EN.
- Defined: adds output miss_cnt [15:0], a saturating count of decode misses (stops at 16'hffff), reset to 0. Also adds input miss_cnt_clr, a synchronous clear. When clear and a miss occur in the same cycle, the counter becomes 1.
- Undefined: the ports are absent and there is no counter logic.

Decomposition:
- Shared header bridge_pkg.vh holds:
  - default window constants (CONF/ROM/PERIPH/SRAM base and mask)
  - MISS_DATA default
  - the stage-field width macro
- Sub-module bridge_addr_dec holds the parametrised comparator bank and priority encoder, producing sel[NSLV-1:0] and miss. It is reused by the future instruction-side bridge.
- Pipeline flops use sirv_gnrl_dfflr with lden = 1.

Test Plan:
- Read 0x1faf_f020 with RD_LAT = 1 -> slv_en = 4'b0001. Cycle+1: rdata = slv_rdata[0], even though 0x1faf_f020 also hits slot 2 (0x1f00_0000 window).
- Back-to-back reads 0x0000_1000, 0x1fc0_0004, 0x1f00_0010 with RD_LAT = 3 -> rdata equals slave 3, 1, 2 data in cycles 3, 4, 5.
- Write wen = 4'hf to 0x1000_0000 -> no slv_en. miss_pulse high for exactly 1 cycle. miss_addr = 32'h1000_0000.
- Read 0x1234_5678 (miss) -> rdata = 32'hdead_beef after RD_LAT cycles.
- Assert reset low mid-stream with a read in stage 0 -> rdata = 0 and miss_pulse = 0 immediately (async). After release there is no stale response.
- With BRIDGE_MISS_CNT_EN, 0x1_0000 misses -> miss_cnt saturates at 16'hffff. Clear and a miss in the same cycle -> miss_cnt = 1.

Source files
------------

// File: rtl/bridge_pkg.sv
// rtl/bridge_pkg.sv - default address windows, miss data and stage layout for the data-side bridge
package bridge_pkg;

    localparam logic [31:0] CONF_BASE   = 32'h1faf_0000;
    localparam logic [31:0] CONF_MASK   = 32'h1fff_0000;
    localparam logic [31:0] ROM_BASE    = 32'h1fc0_0000;
    localparam logic [31:0] ROM_MASK    = 32'h1ff0_0000;
    localparam logic [31:0] PERIPH_BASE = 32'h1f00_0000;
    localparam logic [31:0] PERIPH_MASK = 32'h1f00_0000;
    localparam logic [31:0] SRAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] SRAM_MASK   = 32'h1000_0000;

    localparam logic [31:0] MISS_DATA_DEF = 32'hdead_beef;

    // Stage word is {sel[nslv-1:0], miss_flag, rd_flag}
    function automatic int stage_w(input int nslv);
        return nslv + 2;
    endfunction

endpackage

// File: rtl/bridge_addr_dec.sv
// rtl/bridge_addr_dec.sv - base/mask comparator bank with lowest-index-wins priority select
module bridge_addr_dec #(
    parameter int                     XLEN     = 32,
    parameter int                     NSLV     = 4,
    parameter logic [NSLV*XLEN-1:0]   SLV_BASE = '0,
    parameter logic [NSLV*XLEN-1:0]   SLV_MASK = '0
) (
    input  logic [XLEN-1:0] addr,
    output logic [NSLV-1:0] sel,
    output logic            miss
);

    logic [NSLV-1:0] hit;

    for (genvar i = 0; i < NSLV; i++) begin : g_cmp
        assign hit[i] = ((addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]);
    end

    // Isolate the lowest set bit so overlapping windows resolve to one slave
    assign sel  = hit & (~hit + NSLV'(1));
    assign miss = ~|hit;

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// rtl/sirv_gnrl_dfflr.sv - load-enabled flop bank with async active-low clear
module sirv_gnrl_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/bridge_1xn.sv
// rtl/bridge_1xn.sv - 1-to-N data bridge with RD_LAT select pipeline; BRIDGE_MISS_CNT_EN adds a miss counter
module bridge_1xn
    import bridge_pkg::*;
#(
    parameter int                   XLEN      = 32,
    parameter int                   NSLV      = 4,
    parameter int                   RD_LAT    = 1,
    parameter logic [NSLV*XLEN-1:0] SLV_BASE  = {SRAM_BASE, PERIPH_BASE, ROM_BASE, CONF_BASE},
    parameter logic [NSLV*XLEN-1:0] SLV_MASK  = {SRAM_MASK, PERIPH_MASK, ROM_MASK, CONF_MASK},
    parameter logic [XLEN-1:0]      MISS_DATA = MISS_DATA_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_data_en,
    input  logic [3:0]           cpu_data_wen,
    input  logic [XLEN-1:0]      cpu_data_addr,
    input  logic [XLEN-1:0]      cpu_data_wdata,
    output logic [XLEN-1:0]      cpu_data_rdata,
    output logic [NSLV-1:0]      slv_en,
    output logic [4*NSLV-1:0]    slv_wen,
    output logic [XLEN-1:0]      slv_addr,
    output logic [XLEN-1:0]      slv_wdata,
    input  logic [XLEN*NSLV-1:0] slv_rdata,
    output logic                 miss_pulse,
    output logic [XLEN-1:0]      miss_addr
`ifdef BRIDGE_MISS_CNT_EN
    ,
    input  logic                 miss_cnt_clr,
    output logic [15:0]          miss_cnt
`endif
);

    localparam int SW = stage_w(NSLV);

    logic [NSLV-1:0]             sel;
    logic                        miss;
    logic                        miss_hit;
    logic [RD_LAT-1:0][SW-1:0]   stg_q;
    logic [NSLV-1:0]             l_sel;
    logic                        l_miss;
    logic                        unused_rd;

    bridge_addr_dec #(
        .XLEN     (XLEN),
        .NSLV     (NSLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr (cpu_data_addr),
        .sel  (sel),
        .miss (miss)
    );

    assign slv_en    = sel & {NSLV{cpu_data_en}};
    assign slv_addr  = cpu_data_addr;
    assign slv_wdata = cpu_data_wdata;
    assign miss_hit  = cpu_data_en & miss;

    for (genvar i = 0; i < NSLV; i++) begin : g_wen
        assign slv_wen[i*4 +: 4] = cpu_data_wen & {4{sel[i]}};
    end

    for (genvar k = 0; k < RD_LAT; k++) begin : g_stg
        logic [SW-1:0] stg_d;
        if (k == 0) begin : g_head
            assign stg_d = {slv_en, miss_hit, cpu_data_en & ~|cpu_data_wen};
        end else begin : g_tail
            assign stg_d = stg_q[k-1];
        end
        sirv_gnrl_dfflr #(.DW(SW)) u_stg (
            .clk   (clk),
            .rst_n (reset),
            .lden  (1'b1),
            .dnxt  (stg_d),
            .qout  (stg_q[k])
        );
    end

    // Writes still steer the mux; the rd flag is carried for observability only
    assign {l_sel, l_miss, unused_rd} = stg_q[RD_LAT-1];

    always_comb begin
        cpu_data_rdata = {XLEN{l_miss}} & MISS_DATA;
        for (int i = 0; i < NSLV; i++) begin
            cpu_data_rdata = cpu_data_rdata | ({XLEN{l_sel[i]}} & slv_rdata[i*XLEN +: XLEN]);
        end
    end

    sirv_gnrl_dfflr #(.DW(1)) u_miss_pulse (
        .clk   (clk),
        .rst_n (reset),
        .lden  (1'b1),
        .dnxt  (miss_hit),
        .qout  (miss_pulse)
    );

    sirv_gnrl_dfflr #(.DW(XLEN)) u_miss_addr (
        .clk   (clk),
        .rst_n (reset),
        .lden  (miss_hit),
        .dnxt  (cpu_data_addr),
        .qout  (miss_addr)
    );

`ifdef BRIDGE_MISS_CNT_EN
    logic [15:0] miss_cnt_nxt;

    // A clear coinciding with a miss restarts the count at one
    always_comb begin
        miss_cnt_nxt = miss_cnt;
        if (miss_cnt_clr) begin
            miss_cnt_nxt = {15'd0, miss_hit};
        end else if (miss_hit && (miss_cnt != 16'hffff)) begin
            miss_cnt_nxt = miss_cnt + 16'd1;
        end
    end

    sirv_gnrl_dfflr #(.DW(16)) u_miss_cnt (
        .clk   (clk),
        .rst_n (reset),
        .lden  (1'b1),
        .dnxt  (miss_cnt_nxt),
        .qout  (miss_cnt)
    );
`endif

endmodule

// File: tb/tb_bridge_1xn.sv
// tb/tb_bridge_1xn.sv - scoreboard bench for bridge_1xn at RD_LAT 1 and 3
module tb_bridge_1xn;

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        pulse;
        logic [31:0] maddr;
    } exp_t;

    localparam logic [31:0] TAG [4] = '{32'h0000_00a0, 32'h0000_00b1, 32'h0000_00c2, 32'h0000_00d3};

    logic        clk;
    logic        reset;
    logic        cpu_data_en;
    logic [3:0]  cpu_data_wen;
    logic [31:0] cpu_data_addr;
    logic [31:0] cpu_data_wdata;

    logic [31:0]  u1_rdata, u3_rdata;
    logic [3:0]   u1_slv_en, u3_slv_en;
    logic [15:0]  u1_slv_wen, u3_slv_wen;
    logic [31:0]  u1_slv_addr, u3_slv_addr;
    logic [31:0]  u1_slv_wdata, u3_slv_wdata;
    logic [127:0] u1_slv_rdata, u3_slv_rdata;
    logic         u1_miss_pulse, u3_miss_pulse;
    logic [31:0]  u1_miss_addr, u3_miss_addr;
`ifdef BRIDGE_MISS_CNT_EN
    logic         miss_cnt_clr;
    logic [15:0]  u1_miss_cnt, u3_miss_cnt;
`endif

    logic [31:0] a1;
    logic [31:0] a3 [3];
    int          cyc;
    int          n_chk;
    int          n_fail;
    logic [31:0] last_miss;
    exp_t        q1[$];
    exp_t        q3[$];

    bridge_1xn #(.RD_LAT(1)) u_dut1 (
        .clk            (clk),
        .reset          (reset),
        .cpu_data_en    (cpu_data_en),
        .cpu_data_wen   (cpu_data_wen),
        .cpu_data_addr  (cpu_data_addr),
        .cpu_data_wdata (cpu_data_wdata),
        .cpu_data_rdata (u1_rdata),
        .slv_en         (u1_slv_en),
        .slv_wen        (u1_slv_wen),
        .slv_addr       (u1_slv_addr),
        .slv_wdata      (u1_slv_wdata),
        .slv_rdata      (u1_slv_rdata),
        .miss_pulse     (u1_miss_pulse),
        .miss_addr      (u1_miss_addr)
`ifdef BRIDGE_MISS_CNT_EN
        ,
        .miss_cnt_clr   (miss_cnt_clr),
        .miss_cnt       (u1_miss_cnt)
`endif
    );

    bridge_1xn #(.RD_LAT(3)) u_dut3 (
        .clk            (clk),
        .reset          (reset),
        .cpu_data_en    (cpu_data_en),
        .cpu_data_wen   (cpu_data_wen),
        .cpu_data_addr  (cpu_data_addr),
        .cpu_data_wdata (cpu_data_wdata),
        .cpu_data_rdata (u3_rdata),
        .slv_en         (u3_slv_en),
        .slv_wen        (u3_slv_wen),
        .slv_addr       (u3_slv_addr),
        .slv_wdata      (u3_slv_wdata),
        .slv_rdata      (u3_slv_rdata),
        .miss_pulse     (u3_miss_pulse),
        .miss_addr      (u3_miss_addr)
`ifdef BRIDGE_MISS_CNT_EN
        ,
        .miss_cnt_clr   (miss_cnt_clr),
        .miss_cnt       (u3_miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        a1    <= u1_slv_addr;
        a3[0] <= u3_slv_addr;
        a3[1] <= a3[0];
        a3[2] <= a3[1];
    end

    // Slave models: each returns the address it saw RD_LAT cycles ago xor its tag
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            u1_slv_rdata[i*32 +: 32] = a1 ^ TAG[i];
            u3_slv_rdata[i*32 +: 32] = a3[2] ^ TAG[i];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_wen(input logic [3:0] esel, input logic [3:0] wen);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) r[i*4 +: 4] = esel[i] ? wen : 4'h0;
        return r;
    endfunction

    task automatic issue(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                         input logic [3:0] esel, input logic [31:0] erd, input logic emiss,
                         input bit killed);
        exp_t e;
        cpu_data_en    = en;
        cpu_data_wen   = wen;
        cpu_data_addr  = addr;
        cpu_data_wdata = ~addr;
        #1;
        chk("slv_en", {28'd0, u1_slv_en}, {28'd0, esel});
        chk("slv_wen", {16'd0, u1_slv_wen}, {16'd0, exp_wen(esel, wen)});
        chk("slv_wdata", u3_slv_wdata, ~addr);
        if (killed) last_miss = 32'd0;
        else if (en && emiss) last_miss = addr;
        e.due   = cyc + 1;
        e.rd    = (en && !killed) ? erd : 32'd0;
        e.pulse = en && emiss && !killed;
        e.maddr = last_miss;
        q1.push_back(e);
        e.due   = cyc + 3;
        q3.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q1.size() > 0 && q1[0].due < cyc) begin
                chk("q1_late", 32'(q1[0].due), 32'(cyc));
                void'(q1.pop_front());
            end
            while (q3.size() > 0 && q3[0].due < cyc) begin
                chk("q3_late", 32'(q3[0].due), 32'(cyc));
                void'(q3.pop_front());
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                chk("rdata_lat1", u1_rdata, e.rd);
                chk("miss_pulse1", {31'd0, u1_miss_pulse}, {31'd0, e.pulse});
                chk("miss_pulse3", {31'd0, u3_miss_pulse}, {31'd0, e.pulse});
                chk("miss_addr1", u1_miss_addr, e.maddr);
                chk("miss_addr3", u3_miss_addr, e.maddr);
            end
            if (q3.size() > 0 && q3[0].due == cyc) begin
                e = q3.pop_front();
                chk("rdata_lat3", u3_rdata, e.rd);
            end
        end
    end

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        cyc            = 0;
        last_miss      = 32'd0;
        reset          = 1'b0;
        cpu_data_en    = 1'b0;
        cpu_data_wen   = 4'h0;
        cpu_data_addr  = 32'd0;
        cpu_data_wdata = 32'd0;
`ifdef BRIDGE_MISS_CNT_EN
        miss_cnt_clr   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata1", u1_rdata, 32'd0);
        chk("rst_rdata3", u3_rdata, 32'd0);
        chk("rst_pulse", {31'd0, u1_miss_pulse}, 32'd0);
        chk("rst_maddr", u1_miss_addr, 32'd0);
        reset = 1'b1;

        issue(1, 4'h0, 32'h1faf_f020, 4'b0001, 32'h1faf_f080, 0, 0);
        issue(1, 4'h0, 32'h0000_1000, 4'b1000, 32'h0000_10d3, 0, 0);
        issue(1, 4'h0, 32'h1fc0_0004, 4'b0010, 32'h1fc0_00b5, 0, 0);
        issue(1, 4'h0, 32'h1f00_0010, 4'b0100, 32'h1f00_00d2, 0, 0);
        issue(1, 4'hf, 32'h1000_0000, 4'b0000, 32'hdead_beef, 1, 0);
        issue(0, 4'h0, 32'h0000_0000, 4'b0000, 32'h0000_0000, 0, 0);
        issue(1, 4'h0, 32'h1234_5678, 4'b0000, 32'hdead_beef, 1, 0);
        issue(1, 4'h3, 32'h1fc0_0008, 4'b0010, 32'h1fc0_00b9, 0, 0);
        issue(0, 4'h0, 32'h1faf_0000, 4'b0000, 32'h0000_0000, 0, 0);
        issue(1, 4'h0, 32'h1faf_0004, 4'b0001, 32'h1faf_00a4, 0, 0);
        issue(1, 4'h0, 32'h1fbf_ffff, 4'b0100, 32'h1fbf_ff3d, 0, 0);
        issue(1, 4'h0, 32'hffff_fffc, 4'b0100, 32'hffff_ff3e, 0, 0);
        issue(1, 4'h0, 32'h0fff_fffc, 4'b1000, 32'h0fff_ff2f, 0, 0);
        repeat (3) issue(0, 4'h0, 32'h0, 4'b0000, 32'h0, 0, 0);

        // Reset lands while a miss read sits in stage 0
        issue(1, 4'h0, 32'h1234_5678, 4'b0000, 32'hdead_beef, 1, 1);
        chk("pre_rst_pulse", {31'd0, u1_miss_pulse}, 32'd1);
        chk("pre_rst_rdata", u1_rdata, 32'hdead_beef);
        reset = 1'b0;
        #1;
        chk("async_rdata", u1_rdata, 32'd0);
        chk("async_pulse", {31'd0, u1_miss_pulse}, 32'd0);
        chk("async_maddr", u1_miss_addr, 32'd0);
        issue(1, 4'h0, 32'h1faf_f020, 4'b0001, 32'h1faf_f080, 0, 1);
        issue(1, 4'h0, 32'h1faf_f020, 4'b0001, 32'h1faf_f080, 0, 1);
        reset = 1'b1;
        repeat (3) issue(0, 4'h0, 32'h0, 4'b0000, 32'h0, 0, 0);

        issue(1, 4'h0, 32'h2000_0000, 4'b1000, 32'h2000_00d3, 0, 0);
        issue(1, 4'h0, 32'h1000_0004, 4'b0000, 32'hdead_beef, 1, 0);
        repeat (4) issue(0, 4'h0, 32'h0, 4'b0000, 32'h0, 0, 0);

        for (int i = 0; i < 20 && (q1.size() > 0 || q3.size() > 0); i++) @(posedge clk);
        #1;
        chk("drain", 32'(q1.size() + q3.size()), 32'd0);

`ifdef BRIDGE_MISS_CNT_EN
        miss_cnt_clr = 1'b1;
        cpu_data_en  = 1'b0;
        @(posedge clk);
        #1;
        chk("cnt_clr", {16'd0, u1_miss_cnt}, 32'd0);
        miss_cnt_clr  = 1'b0;
        cpu_data_en   = 1'b1;
        cpu_data_wen  = 4'h0;
        cpu_data_addr = 32'h1234_5678;
        repeat (65537) @(posedge clk);
        #1;
        chk("cnt_sat", {16'd0, u3_miss_cnt}, 32'h0000_ffff);
        miss_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("cnt_clr_miss", {16'd0, u1_miss_cnt}, 32'd1);
        miss_cnt_clr = 1'b0;
        cpu_data_en  = 1'b0;
        @(posedge clk);
        #1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
